// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler FSM encoding,
// control-word bit layout seen by the SOC IO read mux, and the default line setup.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } tx_state_t;

    localparam int CTRL_BUSY_BIT  = 9;
    localparam int CTRL_FULL_BIT  = 10;
    localparam int CTRL_EMPTY_BIT = 11;
    localparam int CTRL_OVF_BIT   = 12;
    localparam int CTRL_CNT_LSB   = 16;
    localparam int CTRL_CNT_MSB   = 20;

    // 115200 baud, 8N1
    localparam logic [23:0] UART_SETUP = 24'h000364;

    function automatic logic [31:0] ctrl_word(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [4:0] cnt);
        logic [31:0] w;
        w                             = '0;
        w[CTRL_BUSY_BIT]              = busy;
        w[CTRL_FULL_BIT]              = full;
        w[CTRL_EMPTY_BIT]             = empty;
        w[CTRL_OVF_BIT]               = ovf;
        w[CTRL_CNT_MSB:CTRL_CNT_LSB]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count,
// so naturally wrapping pointers never need comparing.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_push;
    logic                  do_pop;

    // flush overrides both ports so a same-cycle write is discarded
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + CNT_ONE;
        else if (do_pop && !do_push)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: queues CPU bytes and hands them to txuart one at a time,
// pacing each issue on the serialiser's busy flag.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                flush,
    input  logic                clr_ovf,
    input  logic                tx_busy,
    output logic                tx_wr,
    output logic [DATA_W-1:0]   tx_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                tx_idle
);
    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              pop;
    logic [DATA_W-1:0] fifo_rd_data;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_valid),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // SETTLE ignores tx_busy: txuart needs a cycle to raise it after i_wr
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!empty && !tx_busy && !flush) state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!tx_busy) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_wr   = (state == ST_ISSUE);
        pop     = (state == ST_IDLE) && !empty && !tx_busy && !flush;
        tx_idle = empty && (state == ST_IDLE) && !tx_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    tx_data <= '0;
        else if (pop) tx_data <= fifo_rd_data;
    end

    // a dropped write outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (wr_valid && full && !flush)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a byte-queue reference model with transfer timing rules,
// driven by directed scenarios plus randomized traffic from a simple txuart stand-in.
module tb_uart_tx_sched;
    localparam int DEPTH_LOG2 = 4;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              clr_ovf;
    logic              tx_busy;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [DEPTH_LOG2:0] count;
    logic              overflow;
    logic              tx_idle;

    always #5 clk = ~clk;

    uart_tx_sched #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .tx_busy  (tx_busy),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_idle  (tx_idle)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: queued bytes plus what the transmitter should be doing
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_idle;
    bit         m_txwr;
    logic [7:0] m_txdata;
    int         cyc;
    int         issue_at;
    // txuart stand-in
    int         bcnt;
    int         frame;
    bit         hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_idle   = 1'b1;
        m_txwr   = 1'b0;
        m_txdata = 8'h00;
        issue_at = 0;
        bcnt     = 0;
        hold     = 1'b0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_count", count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_tx_wr", tx_wr, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_idle", tx_idle, 1);
    endtask

    // asserts reset wherever time currently is, checks outputs before any clock edge
    task automatic apply_reset();
        reset    = 1'b1;
        tx_busy  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        clr_ovf  = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_tx_wr_held", tx_wr, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit fl, input bit clr);
        bit busy_v;
        bit full_b;
        bit pop;
        @(negedge clk);
        busy_v = hold || (bcnt > 0);
        if (bcnt > 0) bcnt--;
        tx_busy  = busy_v;
        wr_valid = wr;
        wr_data  = d;
        flush    = fl;
        clr_ovf  = clr;
        #1;
        check_eq("count", count, q.size());
        check_eq("full", full, q.size() == DEPTH);
        check_eq("empty", empty, q.size() == 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("tx_wr", tx_wr, m_txwr);
        check_eq("tx_data", tx_data, m_txdata);
        check_eq("tx_idle", tx_idle, (q.size() == 0) && m_idle && !busy_v);
        if (tx_wr) bcnt = frame;

        full_b = (q.size() == DEPTH);
        pop    = m_idle && (q.size() > 0) && !busy_v && !fl;
        m_txwr = pop;
        if (pop) begin
            m_txdata = q.pop_front();
            m_idle   = 1'b0;
            issue_at = cyc + 1;
        end else if (!m_idle && cyc >= issue_at + 2 && !busy_v) begin
            m_idle = 1'b1;
        end
        if (fl)
            q.delete();
        else if (wr && !full_b)
            q.push_back(d);
        if (wr && full_b && !fl)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 800 && !(q.size() == 0 && m_idle && bcnt == 0); i++)
            step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc   = 0;
        frame = 10;
        apply_reset();

        // single byte, 10-cycle frame
        step(1, 8'h41, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        check_eq("single_tx_wr", tx_wr, 1);
        check_eq("single_tx_data", tx_data, 8'h41);
        drain();
        check_eq("single_idle", tx_idle, 1);

        // burst of 16 with busy held, then a 17th overflows
        hold = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(0, 8'h00, 0, 0);
        check_eq("burst_count", count, 16);
        check_eq("burst_full", full, 1);
        check_eq("burst_ovf", overflow, 1);
        hold  = 1'b0;
        frame = 3;
        drain();
        step(0, 8'h00, 0, 1);
        step(1, 8'h55, 1, 1);
        step(0, 8'h00, 0, 0);

        // wrap: push 10, drain, push 12, drain
        frame = $urandom_range(1, 6);
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0);
        drain();
        for (int i = 0; i < 12; i++) step(1, 8'($urandom), 0, 0);
        drain();
        check_eq("wrap_empty", empty, 1);

        // push and pop in the same cycle at count 3, then with the FIFO full
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
        hold = 1'b0;
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 0, 0);
        check_eq("pushpop_count", count, 3);
        hold = 1'b1;
        for (int i = 0; i < 14; i++) step(1, 8'($urandom), 0, 0);
        hold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_idle && bcnt == 0) begin
                step(1, 8'hAA, 0, 0);
                break;
            end
            step(0, 8'h00, 0, 0);
        end
        step(0, 8'h00, 0, 0);
        check_eq("fullpop_ovf", overflow, 1);
        check_eq("fullpop_count", count, 15);
        drain();
        step(0, 8'h00, 0, 1);

        // flush while a byte is draining
        frame = 10;
        for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 0, 0);
        for (int i = 0; i < 50; i++) begin
            if (!m_idle && cyc >= issue_at + 2) begin
                step(0, 8'h00, 1, 0);
                break;
            end
            step(0, 8'h00, 0, 0);
        end
        for (int i = 0; i < 30; i++) step(0, 8'h00, 0, 0);
        check_eq("flush_count", count, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            frame = $urandom_range(1, 12);
            if ($urandom_range(0, 99) < 3) hold = ~hold;
            step($urandom_range(0, 99) < 40, 8'($urandom),
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        end
        hold = 1'b0;
        drain();

        // async reset during SETTLE with overflow set and a byte in flight
        hold = 1'b1;
        for (int i = 0; i < 17; i++) step(1, 8'h80 + 8'(i), 0, 0);
        hold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(0, 8'h00, 0, 0);
            if (m_txwr) break;
        end
        step(0, 8'h00, 0, 0);
        check_eq("pre_rst_tx_wr", tx_wr, 1);
        @(posedge clk);
        #2;
        apply_reset();
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);
        step(1, 8'h5A, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
